// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions for the multiply unit.
//   XLEN        : operand / register width
//   OP_MUL      : decoded opcode of the MUL instruction
//   mul_state_t : control states of the sequential multiplier
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0] OP_MUL = 8'b00011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// -----------------------------------------------------------------------------
// mul_shift_add
// Shift-add datapath of the sequential multiplier: one multiplier bit is
// consumed per step, the multiplicand shifts left into a 2*XLEN accumulator.
//
// Optional build macro MUL_SIGNED_EN: operands are two's complement. Their
// magnitudes are multiplied and the product is negated when the signs differ.
// Without it the operands are unsigned and no sign logic exists.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture opa/opb and clear the accumulator
//   step       : perform one shift-add iteration
//   opa, opb   : multiplicand, multiplier
//   product    : accumulator value after the current step (sign-corrected);
//                valid as the final product during the last step
// -----------------------------------------------------------------------------
module mul_shift_add #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] product
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [2*XLEN-1:0] acc_sum;
  logic [XLEN-1:0]   mplr_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

`ifdef MUL_SIGNED_EN
  logic neg_q;

  // The magnitude of the most negative value still fits in XLEN unsigned bits.
  assign mag_a   = opa[XLEN-1] ? -opa : opa;
  assign mag_b   = opb[XLEN-1] ? -opb : opb;
  assign product = neg_q ? -acc_sum : acc_sum;
`else
  assign mag_a   = opa;
  assign mag_b   = opb;
  assign product = acc_sum;
`endif

  assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: these are plain flops, not a memory, so they are cheap to reset and
  // a reset keeps simulation free of X on product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (load) begin
      acc_q   <= '0;
      mcand_q <= {{XLEN{1'b0}}, mag_a};
      mplr_q  <= mag_b;
`ifdef MUL_SIGNED_EN
      neg_q   <= opa[XLEN-1] ^ opb[XLEN-1];
`endif
    end else if (step) begin
      acc_q   <= acc_sum;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential (shift-add) multiplier for the EX stage. Takes exactly XLEN BUSY
// cycles; the pipeline is stalled from the accepting cycle until the DONE
// cycle, in which done/wb_en pulse for one cycle with the full product.
//
// Optional build macro MUL_SIGNED_EN: signed (two's complement) operands,
// same latency. Default build is unsigned.
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : decoded MUL valid in EX (accepted only in IDLE)
//   opa, opb   : multiplicand, multiplier
//   rd         : destination register of the MUL
//   flush      : abort; returns to IDLE next cycle without a result pulse
//   stall      : freezes IF/ID/EX while the multiply is pending
//   done       : one-cycle result-valid pulse
//   result     : full 2*XLEN product {hi,lo}, held until the next completion
//   wb_rd      : destination register of the last completed multiply
//   wb_en      : register-write request, identical to done
// -----------------------------------------------------------------------------
module mul_seq #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  input  logic [4:0]        rd,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [2*XLEN-1:0] result,
  output logic [4:0]        wb_rd,
  output logic              wb_en
);

  import cpu_pkg::mul_state_t;
  import cpu_pkg::IDLE;
  import cpu_pkg::BUSY;
  import cpu_pkg::DONE;

  mul_state_t        state_q;
  mul_state_t        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        rd_q;
  logic              load;
  logic              step;
  logic              last_step;
  logic [2*XLEN-1:0] product;

  mul_shift_add #(
    .XLEN (XLEN)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .opa     (opa),
    .opb     (opb),
    .product (product)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        step  = !flush;
        // Counter 1 here means this is the XLEN-th iteration.
        if (cnt_q == CNT_W'(1)) begin
          last_step = !flush;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides every transition, including a simultaneous start.
    if (flush) state_d = IDLE;
  end

  assign wb_en = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      result  <= '0;
      wb_rd   <= '0;
    end else begin
      state_q <= state_d;
      if (flush)     cnt_q <= '0;
      else if (load) cnt_q <= CNT_W'(XLEN);
      else if (step) cnt_q <= cnt_q - CNT_W'(1);
      if (load) rd_q <= rd;
      // Result and wb_rd change only on completion, so they hold otherwise.
      if (last_step) begin
        result <= product;
        wb_rd  <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Self-checking bench for mul_seq. Expected products come from a vector table
// and a behavioural model; expected {result, wb_rd} are queued when a multiply
// is started and compared by a monitor when done pulses. Hand-written
// sequences cover flush, ignored start, and reset during BUSY.
// Honours MUL_SIGNED_EN for the signed expectations.
// -----------------------------------------------------------------------------
module tb_mul_seq;

  localparam int XLEN = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [4:0]        rd;
  logic              flush;
  logic              stall;
  logic              done;
  logic [2*XLEN-1:0] result;
  logic [4:0]        wb_rd;
  logic              wb_en;

  mul_seq #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opa    (opa),
    .opb    (opb),
    .rd     (rd),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result),
    .wb_rd  (wb_rd),
    .wb_en  (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [4:0]        r;
    logic [2*XLEN-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*XLEN-1:0] res;
    logic [4:0]        r;
  } exp_t;

  exp_t              exp_q[$];
  vec_t              vecs[12];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [2*XLEN-1:0] last_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
    model = longint'($signed(a)) * longint'($signed(b));
`else
    model = {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || wb_en) check("wb_en_eq_done", {63'b0, wb_en}, {63'b0, done});
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("wb_rd", {59'b0, wb_rd}, {59'b0, e.r});
        end
      end
    end
  end

  // Runs one multiply that must complete. inject >= 1 re-asserts start (with
  // different operands) during that stall cycle and the next one.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        input logic [63:0] exp, input string name, input int inject);
    int n;
    @(posedge clk); #1;
    start = 1'b1; opa = a; opb = b; rd = r;
    exp_q.push_back('{res: exp, r: r});
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
      if (n == inject || n == inject + 1) begin
        start = 1'b1; opa = 32'd9; opb = 32'd9; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 64'(n), 64'(XLEN + 1));
    check({name, "_done_at_latency"}, {63'b0, done}, 64'd1);
    start = 1'b0;
    @(negedge clk);
    check({name, "_done_one_cycle"}, {63'b0, done}, 64'd0);
    last_res = exp;
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table: {opa, opb, rd, expected product}.
    vecs[0] = '{32'd7,          32'd6,          5'd3,  64'd42};
`ifdef MUL_SIGNED_EN
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   5'd31, 64'd1};
    vecs[4] = '{32'h80000000,   32'd2,          5'd4,  64'hFFFFFFFF00000000};
    vecs[5] = '{32'hFFFFFFFD,   32'd5,          5'd5,  64'hFFFFFFFFFFFFFFF1};
    vecs[7] = '{32'd3,          32'hFFFFFFFF,   5'd7,  64'hFFFFFFFFFFFFFFFD};
`else
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   5'd31, 64'hFFFFFFFE00000001};
    vecs[4] = '{32'h80000000,   32'd2,          5'd4,  64'h0000000100000000};
    vecs[5] = '{32'hFFFFFFFD,   32'd5,          5'd5,  64'h00000004FFFFFFF1};
    vecs[7] = '{32'd3,          32'hFFFFFFFF,   5'd7,  64'h00000002FFFFFFFD};
`endif
    vecs[2] = '{32'd0,          32'd12345,      5'd1,  64'd0};
    vecs[3] = '{32'hDEADBEEF,   32'd0,          5'd2,  64'd0};
    vecs[6] = '{32'h0000FFFF,   32'h0000FFFF,   5'd6,  64'h00000000FFFE0001};
    for (int i = 8; i < 12; i++) begin
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].r   = 5'($urandom_range(1, 31));
      vecs[i].exp = model(vecs[i].a, vecs[i].b);
    end

    start = 1'b0; opa = '0; opb = '0; rd = '0; flush = 1'b0;
    rst_n = 1'b0;
    last_res = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_stall",  {63'b0, stall}, 64'd0);
    check("rst_done",   {63'b0, done},  64'd0);
    check("rst_wb_en",  {63'b0, wb_en}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wb_rd",  {59'b0, wb_rd}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_stall",  {63'b0, stall}, 64'd0);
    check("idle_done",   {63'b0, done},  64'd0);
    check("idle_result", result, 64'd0);

    // Table-driven multiplies.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].exp, $sformatf("vec%0d", i), -1);
    end

    // start re-asserted with opa=9 during BUSY is ignored.
    run_op(32'd4, 32'd5, 5'd8, 64'd20, "ignored_start", 5);
    expect_no_done("ignored_start_no_second_done", 40);
    check("ignored_start_result_held", result, 64'd20);

    // Flush at BUSY cycle 10.
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd100; opb = 32'd100; rd = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_stall_low", {63'b0, stall}, 64'd0);
    check("flush_no_done",   {63'b0, done},  64'd0);
    expect_no_done("flush_no_late_done", 40);
    check("flush_result_held", result, last_res);

    // Flush wins over start in IDLE.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; opa = 32'd5; opb = 32'd5; rd = 5'd11;
    @(negedge clk);
    check("flush_start_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_idle", {63'b0, stall}, 64'd0);
    expect_no_done("flush_start_no_done", 40);

    run_op(32'd2, 32'd3, 5'd12, 64'd6, "after_flush", -1);

    // Reset at BUSY cycle 5 discards the operation.
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd11; opb = 32'd13; rd = 5'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_stall",  {63'b0, stall}, 64'd0);
    check("midrst_done",   {63'b0, done},  64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_wb_rd",  {59'b0, wb_rd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("midrst_no_done", 40);
    check("midrst_stall_after", {63'b0, stall}, 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
